// File: rtl/png_feed_pkg.sv
// png_feed_pkg -- shared definitions for the PNG packet-to-byte feeder.
// Holds the packet geometry, the controller state encoding and a small
// helper used when sizing the byte count of an accepted packet.
package png_feed_pkg;

  localparam int DATA_W      = 552;
  localparam int FRAME_BYTES = 69;   // DATA_W / 8

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PKT = 3'd1,
    ST_START    = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Bytes to play out of a packet: never more than the image still needs.
  function automatic logic [6:0] clip_bytes(input logic [6:0]  nbytes,
                                            input logic [31:0] remaining);
    if (remaining < {25'd0, nbytes}) return remaining[6:0];
    return nbytes;
  endfunction

endpackage

// File: rtl/png_feed_ctrl_if.sv
// png_feed_ctrl_if -- packet bus into the feeder.
// Handshake: the master holds pkt_valid and all pkt_* payload fields stable
// until it sees pkt_ready; a packet transfers on a rising clk edge where
// pkt_valid and pkt_ready are both high. pkt_ready may not depend on
// pkt_valid.
//   pkt_valid  : master -> slave, packet present
//   pkt_ready  : slave -> master, packet can be taken this cycle
//   pkt_data   : payload, first byte in the top 8 bits
//   pkt_ip     : source IP
//   pkt_port   : source port
//   pkt_nbytes : number of valid payload bytes
interface png_feed_ctrl_if #(
  parameter int DATA_W = png_feed_pkg::DATA_W
) ();

  logic              pkt_valid;
  logic              pkt_ready;
  logic [DATA_W-1:0] pkt_data;
  logic [31:0]       pkt_ip;
  logic [15:0]       pkt_port;
  logic [6:0]        pkt_nbytes;

  modport master (
    output pkt_valid, pkt_data, pkt_ip, pkt_port, pkt_nbytes,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_ip, pkt_port, pkt_nbytes,
    output pkt_ready
  );

endinterface

// File: rtl/png_pkt_filter.sv
// png_pkt_filter -- combinational packet acceptance check.
// match is high when the packet comes from the configured IP/port and
// carries between 1 and FRAME_BYTES payload bytes.
//   pkt_ip, pkt_port, pkt_nbytes : fields of the offered packet
//   cfg_ip, cfg_port             : accepted source (compared live)
//   match                        : packet is to be streamed
module png_pkt_filter #(
  parameter int FRAME_BYTES = png_feed_pkg::FRAME_BYTES
) (
  input  logic [31:0] pkt_ip,
  input  logic [15:0] pkt_port,
  input  logic [6:0]  pkt_nbytes,
  input  logic [31:0] cfg_ip,
  input  logic [15:0] cfg_port,
  output logic        match
);

  localparam logic [6:0] MAX_NB = 7'(FRAME_BYTES);

  always_comb begin
    match = (pkt_ip == cfg_ip) && (pkt_port == cfg_port) &&
            (pkt_nbytes != 7'd0) && (pkt_nbytes <= MAX_NB);
  end

endmodule

// File: rtl/png_feed_ctrl.sv
// png_feed_ctrl -- turns network packets into the byte stream of a PNG
// decoder. Matching packets are loaded into a shift register and played
// out one byte at a time until cfg_img_len bytes have been delivered.
//   clk, rstn      : clock, asynchronous active-low reset
//   cfg_en         : run enable; dropping it aborts to IDLE
//   cfg_ip/port    : accepted packet source
//   cfg_img_len    : total image bytes, sampled when leaving IDLE
//   pkt            : packet bus (slave side)
//   ostart         : one-cycle decoder start before the first byte
//   ovalid, obyte  : decoder byte stream, held while iready=0
//   iready         : decoder accepts obyte
//   busy, done     : not IDLE / end-of-image pulse
//   drop_cnt       : saturating count of rejected packets
//   state_dbg      : current FSM state
module png_feed_ctrl #(
  parameter int DATA_W      = png_feed_pkg::DATA_W,
  parameter int FRAME_BYTES = png_feed_pkg::FRAME_BYTES
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_en,
  input  logic [31:0]            cfg_ip,
  input  logic [15:0]            cfg_port,
  input  logic [31:0]            cfg_img_len,
  png_feed_ctrl_if.slave         pkt,
  output logic                   ostart,
  output logic                   ovalid,
  output logic [7:0]             obyte,
  input  logic                   iready,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            drop_cnt,
  output logic [2:0]             state_dbg
);

  import png_feed_pkg::*;

  state_t            state_q, state_d;
  logic [31:0]       remaining_q, remaining_d;
  logic [6:0]        byte_cnt_q, byte_cnt_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ostart_q, ostart_d;
  logic              ovalid_q, ovalid_d;
  logic [7:0]        obyte_q, obyte_d;
  logic              done_q, done_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic match;
  logic pkt_hs;
  logic byte_xfer;

  png_pkt_filter #(.FRAME_BYTES(FRAME_BYTES)) u_filter (
    .pkt_ip     (pkt.pkt_ip),
    .pkt_port   (pkt.pkt_port),
    .pkt_nbytes (pkt.pkt_nbytes),
    .cfg_ip     (cfg_ip),
    .cfg_port   (cfg_port),
    .match      (match)
  );

  assign pkt.pkt_ready = (state_q == ST_WAIT_PKT);
  assign pkt_hs        = pkt.pkt_valid && (state_q == ST_WAIT_PKT);
  assign byte_xfer     = ovalid_q && iready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    byte_cnt_d  = byte_cnt_q;
    first_d     = first_q;
    shift_d     = shift_q;
    ostart_d    = 1'b0;
    ovalid_d    = ovalid_q;
    obyte_d     = obyte_q;
    done_d      = 1'b0;
    drop_cnt_d  = drop_cnt_q;

    if ((state_q != ST_IDLE) && !cfg_en) begin
      // Abort: whatever is in flight is thrown away, no done pulse.
      state_d     = ST_IDLE;
      remaining_d = '0;
      byte_cnt_d  = '0;
      first_d     = 1'b0;
      shift_d     = '0;
      ovalid_d    = 1'b0;
      obyte_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ovalid_d = 1'b0;
          if (cfg_en && (cfg_img_len != 32'd0)) begin
            remaining_d = cfg_img_len;
            first_d     = 1'b1;
            state_d     = ST_WAIT_PKT;
          end
        end

        ST_WAIT_PKT: begin
          if (pkt_hs) begin
            if (match) begin
              shift_d    = pkt.pkt_data;
              byte_cnt_d = clip_bytes(pkt.pkt_nbytes, remaining_q);
              if (first_q) begin
                ostart_d = 1'b1;
                state_d  = ST_START;
              end else begin
                // Later packets go straight to streaming, so the first
                // byte is presented from the incoming payload.
                ovalid_d = 1'b1;
                obyte_d  = pkt.pkt_data[DATA_W-1 -: 8];
                state_d  = ST_STREAM;
              end
            end else if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end
          end
        end

        ST_START: begin
          first_d  = 1'b0;
          ovalid_d = 1'b1;
          obyte_d  = shift_q[DATA_W-1 -: 8];
          state_d  = ST_STREAM;
        end

        ST_STREAM: begin
          if (byte_xfer) begin
            shift_d     = shift_q << 8;
            byte_cnt_d  = byte_cnt_q - 7'd1;
            remaining_d = remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
              ovalid_d = 1'b0;
              done_d   = 1'b1;
              state_d  = ST_DONE;
            end else if (byte_cnt_q == 7'd1) begin
              ovalid_d = 1'b0;
              state_d  = ST_WAIT_PKT;
            end else begin
              // Next byte is the one just below the outgoing top byte.
              obyte_d = shift_q[DATA_W-9 -: 8];
            end
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d  = ST_IDLE;
          ovalid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      byte_cnt_q  <= '0;
      first_q     <= 1'b0;
      shift_q     <= '0;
      ostart_q    <= 1'b0;
      ovalid_q    <= 1'b0;
      obyte_q     <= '0;
      done_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      byte_cnt_q  <= byte_cnt_d;
      first_q     <= first_d;
      shift_q     <= shift_d;
      ostart_q    <= ostart_d;
      ovalid_q    <= ovalid_d;
      obyte_q     <= obyte_d;
      done_q      <= done_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign ostart    = ostart_q;
  assign ovalid    = ovalid_q;
  assign obyte     = obyte_q;
  assign done      = done_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_png_feed_ctrl.sv
// tb_png_feed_ctrl -- directed bench for png_feed_ctrl.
// Every cycle is handled at the falling edge: outputs are observed, then
// the next inputs are driven. A byte is recorded when ovalid and iready are
// both high at that point, i.e. it will transfer on the coming rising edge.
module tb_png_feed_ctrl;

  import png_feed_pkg::*;

  localparam logic [31:0] IP   = 32'hC0A8_0001;
  localparam logic [15:0] PORT = 16'd5000;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [31:0]       ip;
    logic [15:0]       port;
    logic [6:0]        nbytes;
  } pkt_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        cfg_en;
  logic [31:0] cfg_ip;
  logic [15:0] cfg_port;
  logic [31:0] cfg_img_len;
  logic        ostart, ovalid, iready, busy, done;
  logic [7:0]  obyte;
  logic [15:0] drop_cnt;
  logic [2:0]  state_dbg;

  png_feed_ctrl_if #(.DATA_W(DATA_W)) pkt_bus ();

  png_feed_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_en      (cfg_en),
    .cfg_ip      (cfg_ip),
    .cfg_port    (cfg_port),
    .cfg_img_len (cfg_img_len),
    .pkt         (pkt_bus.slave),
    .ostart      (ostart),
    .ovalid      (ovalid),
    .obyte       (obyte),
    .iready      (iready),
    .busy        (busy),
    .done        (done),
    .drop_cnt    (drop_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  pkt_t       pkt_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ref_q[$];

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int ostart_cnt, done_cnt, ovalid_cnt;
  int ostart_cyc, first_ov_cyc, last_ov_cyc, done_cyc;
  bit hs_pend = 1'b0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_obyte = 8'd0;
  bit en_drive = 1'b0;
  int iready_mode = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic pkt_t make_pkt(input logic [7:0] base, input logic [31:0] ip,
                                    input logic [15:0] port, input logic [6:0] nb);
    pkt_t p;
    p.data = '0;
    for (int i = 0; i < FRAME_BYTES; i++) p.data[DATA_W-1-8*i -: 8] = base + 8'(i);
    p.ip     = ip;
    p.port   = port;
    p.nbytes = nb;
    return p;
  endfunction

  task automatic push_exp(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
  endtask

  task automatic reset_counts();
    ostart_cnt = 0; done_cnt = 0; ovalid_cnt = 0;
    ostart_cyc = -1; first_ov_cyc = -1; last_ov_cyc = -1; done_cyc = -1;
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (hs_pend && pkt_q.size() > 0) void'(pkt_q.pop_front());
    if (prev_hold) begin
      check_eq("hold_ovalid", ovalid, 1);
      check_eq("hold_obyte", obyte, prev_obyte);
    end
    if (ostart) begin
      ostart_cnt++;
      ostart_cyc = cyc;
      check_eq("ostart_no_ovalid", ovalid, 0);
    end
    if (ovalid) begin
      ovalid_cnt++;
      if (first_ov_cyc < 0) first_ov_cyc = cyc;
      last_ov_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      en_drive = 1'b0;
    end
    cfg_en = en_drive;
    if (pkt_q.size() > 0) begin
      pkt_bus.pkt_valid  = 1'b1;
      pkt_bus.pkt_data   = pkt_q[0].data;
      pkt_bus.pkt_ip     = pkt_q[0].ip;
      pkt_bus.pkt_port   = pkt_q[0].port;
      pkt_bus.pkt_nbytes = pkt_q[0].nbytes;
    end else begin
      pkt_bus.pkt_valid  = 1'b0;
    end
    iready     = (iready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    hs_pend    = pkt_bus.pkt_valid && pkt_bus.pkt_ready;
    prev_hold  = ovalid && !iready && cfg_en;
    prev_obyte = obyte;
    if (ovalid && iready) got_q.push_back(obyte);
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    check_eq({tag, "_done_seen"}, done_cnt > 0, 1);
    cycle();
    check_eq({tag, "_idle_after_done"}, busy, 0);
    check_eq({tag, "_done_once"}, done_cnt, 1);
  endtask

  task automatic compare_stream(input string tag);
    check_eq({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    cfg_en = 1'b0; cfg_ip = IP; cfg_port = PORT; cfg_img_len = 32'd0;
    iready = 1'b0;
    pkt_bus.pkt_valid = 1'b0; pkt_bus.pkt_data = '0; pkt_bus.pkt_ip = '0;
    pkt_bus.pkt_port = '0; pkt_bus.pkt_nbytes = '0;
    reset_counts();
    #12;
    check_eq("rst_ostart", ostart, 0);
    check_eq("rst_ovalid", ovalid, 0);
    check_eq("rst_obyte", obyte, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
    check_eq("rst_pkt_ready", pkt_bus.pkt_ready, 0);
    check_eq("rst_state", state_dbg, ST_IDLE);
    @(negedge clk);
    rstn = 1'b1;

    // Zero-length image: enable alone must not leave IDLE.
    cfg_img_len = 32'd0;
    en_drive = 1'b1;
    repeat (3) cycle();
    check_eq("zero_len_busy", busy, 0);
    en_drive = 1'b0;
    cycle();

    // Single 69-byte packet, iready always high.
    reset_counts();
    cfg_img_len = 32'd69;
    pkt_q.push_back(make_pkt(8'h10, IP, PORT, 7'd69));
    push_exp(8'h10, 69);
    en_drive = 1'b1;
    run_until_done("t1", 300);
    check_eq("t1_ostart_cnt", ostart_cnt, 1);
    check_eq("t1_ovalid_cnt", ovalid_cnt, 69);
    check_eq("t1_first_byte_after_start", first_ov_cyc, ostart_cyc + 1);
    check_eq("t1_consecutive", last_ov_cyc - first_ov_cyc, 68);
    check_eq("t1_done_after_last", done_cyc, last_ov_cyc + 1);
    compare_stream("t1");
    ref_q = got_q;

    // 100-byte image over two 69-byte packets; tail of packet 2 discarded.
    reset_counts();
    cfg_img_len = 32'd100;
    pkt_q.push_back(make_pkt(8'h20, IP, PORT, 7'd69));
    pkt_q.push_back(make_pkt(8'h70, IP, PORT, 7'd69));
    push_exp(8'h20, 69);
    push_exp(8'h70, 31);
    en_drive = 1'b1;
    run_until_done("t2", 400);
    check_eq("t2_ostart_cnt", ostart_cnt, 1);
    check_eq("t2_ovalid_cnt", ovalid_cnt, 100);
    check_eq("t2_pkts_consumed", pkt_q.size(), 0);
    check_eq("t2_done_after_last", done_cyc, last_ov_cyc + 1);
    compare_stream("t2");

    // Same payload as the first image with iready toggling every cycle.
    reset_counts();
    cfg_img_len = 32'd69;
    pkt_q.push_back(make_pkt(8'h10, IP, PORT, 7'd69));
    exp_q = ref_q;
    iready_mode = 1;
    en_drive = 1'b1;
    run_until_done("t3", 600);
    iready_mode = 0;
    check_eq("t3_ostart_cnt", ostart_cnt, 1);
    compare_stream("t3");

    // Wrong port, zero-length, then a matching packet.
    reset_counts();
    cfg_img_len = 32'd69;
    pkt_q.push_back(make_pkt(8'h40, IP, PORT + 16'd1, 7'd69));
    pkt_q.push_back(make_pkt(8'h50, IP, PORT, 7'd0));
    pkt_q.push_back(make_pkt(8'h80, IP, PORT, 7'd69));
    push_exp(8'h80, 69);
    en_drive = 1'b1;
    run_until_done("t4", 400);
    check_eq("t4_drop_cnt", drop_cnt, 2);
    check_eq("t4_ostart_cnt", ostart_cnt, 1);
    compare_stream("t4");

    // Abort after byte 10, then re-enable.
    reset_counts();
    cfg_img_len = 32'd69;
    pkt_q.push_back(make_pkt(8'h30, IP, PORT, 7'd69));
    push_exp(8'h30, 10);
    en_drive = 1'b1;
    begin
      int n = 0;
      while (got_q.size() < 10 && n < 200) begin
        cycle();
        n++;
      end
    end
    check_eq("t5_reached_10", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      check_eq($sformatf("t5_b%0d", i), got_q[i], exp_q[i]);
    en_drive = 1'b0;
    cycle();
    cycle();
    check_eq("t5_abort_ovalid", ovalid, 0);
    check_eq("t5_abort_busy", busy, 0);
    repeat (3) cycle();
    check_eq("t5_no_done", done_cnt, 0);
    reset_counts();
    pkt_q.push_back(make_pkt(8'h90, IP, PORT, 7'd69));
    push_exp(8'h90, 69);
    en_drive = 1'b1;
    run_until_done("t5r", 300);
    check_eq("t5r_ostart_cnt", ostart_cnt, 1);
    compare_stream("t5r");

    // Asynchronous reset in the middle of streaming.
    reset_counts();
    cfg_img_len = 32'd69;
    pkt_q.push_back(make_pkt(8'hA0, IP, PORT, 7'd69));
    en_drive = 1'b1;
    begin
      int n = 0;
      while (got_q.size() < 5 && n < 200) begin
        cycle();
        n++;
      end
    end
    check_eq("t6_streaming", ovalid, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("t6_rst_ovalid", ovalid, 0);
    check_eq("t6_rst_ostart", ostart, 0);
    check_eq("t6_rst_obyte", obyte, 0);
    check_eq("t6_rst_done", done, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_drop_cnt", drop_cnt, 0);
    en_drive = 1'b0;
    cfg_en = 1'b0;
    pkt_q.delete();
    pkt_bus.pkt_valid = 1'b0;
    hs_pend = 1'b0;
    prev_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cycle();
    check_eq("t6_idle_after_rst", state_dbg, ST_IDLE);
    reset_counts();
    pkt_q.push_back(make_pkt(8'h11, IP, PORT, 7'd69));
    push_exp(8'h11, 69);
    en_drive = 1'b1;
    run_until_done("t6r", 300);
    check_eq("t6r_ostart_cnt", ostart_cnt, 1);
    compare_stream("t6r");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/png_feed_ctrl.md
PNG_FEED_CTRL -- requirements
Module: png_feed_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 552, meaning packet payload width in bits.
REQ-002 SHALL have parameter FRAME_BYTES, default 69, meaning payload bytes per packet (DATA_W/8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports cfg_en / cfg_ip / cfg_port / cfg_img_len, input, 1/32/16/32: run enable, accepted IP, accepted port, total image bytes.
REQ-006 SHALL have ports pkt_valid / pkt_ready, input / output, 1 each: packet handshake; transfer when both are high.
REQ-007 SHALL have ports pkt_data / pkt_ip / pkt_port / pkt_nbytes, input, DATA_W/32/16/7: payload (first byte in bits [DATA_W-1:DATA_W-8]), source IP, port, valid byte count.
REQ-008 SHALL have ports ostart / ovalid / obyte, output, 1/1/8: decoder istart, ivalid and ibyte.
REQ-009 SHALL have port iready, input, 1, decoder byte-accept.
REQ-010 SHALL have ports busy / done / drop_cnt, output, 1/1/16: not IDLE, end-of-image pulse, dropped-packet count.

Function
REQ-011 SHALL implement states IDLE, WAIT_PKT, START, STREAM, DONE.
REQ-012 SHALL, in IDLE, when cfg_en=1 and cfg_img_len!=0, load remaining<=cfg_img_len, set first<=1 and go to WAIT_PKT; if cfg_img_len=0, stay in IDLE.
REQ-013 SHALL drive pkt_ready=1 only in WAIT_PKT, combinationally from state.
REQ-014 SHALL accept a packet as matching when pkt_ip==cfg_ip, pkt_port==cfg_port and 1<=pkt_nbytes<=FRAME_BYTES.
REQ-015 SHALL, on an accepted matching packet, load the shift register with pkt_data and set byte_cnt<=min(pkt_nbytes, remaining). It then goes to START if first=1, else to STREAM.
REQ-016 SHALL consume a non-matching packet (handshake completes), discard it, stay in WAIT_PKT, and increment drop_cnt, saturating at 16'hFFFF.
REQ-017 SHALL, in START, assert ostart=1 for exactly one cycle with ovalid=0, clear first, and go to STREAM.
REQ-018 SHALL, in STREAM, drive ovalid=1 and obyte=shift_reg[DATA_W-1:DATA_W-8], both as registered values.
REQ-019 SHALL hold obyte and ovalid stable while iready=0.
REQ-020 SHALL, on ovalid&iready, shift the register left by 8 and decrement byte_cnt and remaining by 1.
REQ-021 SHALL, on the final byte transfer where remaining becomes 0, go to DONE; unused bytes left in the packet are discarded.
REQ-022 SHALL, when byte_cnt becomes 0 and remaining>0, go to WAIT_PKT with ovalid=0 the next cycle.
REQ-023 SHALL, in DONE, pulse done=1 for one cycle and return to IDLE; a new image needs cfg_en to be high in IDLE.
REQ-024 SHALL, when cfg_en=0 in any non-IDLE state, abort to IDLE on the next edge: ovalid=0, no done pulse, packet contents discarded.
REQ-025 SHALL ignore changes to cfg_ip, cfg_port and cfg_img_len outside IDLE, except that cfg_ip and cfg_port are compared live in WAIT_PKT.
REQ-026 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-027 SHALL, while rstn=0, force state=IDLE and ostart, ovalid, obyte, done, drop_cnt, byte_cnt, remaining, first and the shift register to 0, independent of clk.
REQ-028 SHALL, with rstn=0 mid-STREAM, drop ovalid immediately and resume only via the IDLE flow after rstn rises.

Structure
REQ-029 SHALL take DATA_W, FRAME_BYTES and the state enumeration from shared package png_feed_pkg.
REQ-030 SHALL place the REQ-014 match logic in combinational sub-module png_pkt_filter (output match); all sequential logic stays in png_feed_ctrl.

Verification
REQ-031 SHALL test: cfg_img_len=69, one matching packet with pkt_nbytes=69, iready=1 -> one ostart cycle, then 69 consecutive ovalid bytes in order, then done.
REQ-032 SHALL test: cfg_img_len=100, packets of 69 and 69 bytes -> 100 bytes out, last 38 of packet 2 discarded, single ostart, done after byte 100.
REQ-033 SHALL test: iready toggling 1/0 every cycle -> obyte stable while iready=0; byte sequence identical to the iready=1 run.
REQ-034 SHALL test: packet with wrong pkt_port, then one with pkt_nbytes=0, then a matching one -> drop_cnt=2, only the matching payload streamed.
REQ-035 SHALL test: cfg_en=0 after byte 10 of 69 -> ovalid=0 next cycle, no done, busy=0. Re-enable -> new ostart.
REQ-036 SHALL test: rstn=0 asserted mid-STREAM between clock edges -> all outputs 0 without a clock edge, drop_cnt=0.
